// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-system types: RAM handshake status, data word and the
// memory arbiter state encoding, plus the starvation counter helper.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DREAD  = 2'd1,
    DWRITE = 2'd2,
    IREAD  = 2'd3
  } memarb_state_t;

  localparam int STARVE_W = 4;

  function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v,
                                                  input logic [STARVE_W-1:0] lim);
    return (v >= lim) ? lim : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported RAM between dcache (priority) and icache, with a
// starvation guard that forces an icache grant after IWAIT_MAX dcache grants.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned IWAIT_MAX = 4
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      dwait,
  output logic      iwait,
  output word_t     dload,
  output word_t     iload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
);

  localparam logic [STARVE_W-1:0] IWAIT_LIM = STARVE_W'(IWAIT_MAX);

  memarb_state_t        state_q, state_d;
  logic [STARVE_W-1:0]  starve_q, starve_d;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    dwait    = 1'b1;
    iwait    = 1'b1;
    dload    = '0;
    iload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;

    case (state_q)
      IDLE: begin
        if (iREN && starve_q == IWAIT_LIM) state_d = IREAD;
        else if (dWEN)                     state_d = DWRITE;
        else if (dREN)                     state_d = DREAD;
        else if (iREN)                     state_d = IREAD;
      end
      DREAD: begin
        ramREN  = 1'b1;
        ramaddr = daddr;
        if (!dREN) begin
          state_d = IDLE;
        end else if (ramstate == ACCESS) begin
          dwait   = 1'b0;
          dload   = ramload;
          state_d = IDLE;
        end
      end
      DWRITE: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr;
        ramstore = dstore;
        if (!dWEN) begin
          state_d = IDLE;
        end else if (ramstate == ACCESS) begin
          dwait   = 1'b0;
          state_d = IDLE;
        end
      end
      IREAD: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        if (!iREN) begin
          state_d = IDLE;
        end else if (ramstate == ACCESS) begin
          iwait   = 1'b0;
          iload   = ramload;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Count only dcache grants that overtook a waiting icache request.
    if (!iREN) begin
      starve_d = '0;
    end else if (state_q == IDLE) begin
      if (state_d == IREAD)
        starve_d = '0;
      else if (state_d == DREAD || state_d == DWRITE)
        starve_d = sat_inc(starve_q, IWAIT_LIM);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: cache drivers push expected completions
// into per-cache queues, a negedge monitor pops and compares on each wait pulse.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic      CLK = 1'b0;
  logic      nRST;
  logic      dREN, dWEN, iREN;
  word_t     daddr, dstore, iaddr;
  logic      dwait, iwait;
  word_t     dload, iload;
  logic      ramREN, ramWEN;
  word_t     ramaddr, ramstore, ramload;
  ramstate_t ramstate;

  mem_arbiter #(.IWAIT_MAX(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iREN(iREN), .iaddr(iaddr),
    .dwait(dwait), .iwait(iwait), .dload(dload), .iload(iload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic word_t rd_data(input word_t a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  // RAM model: ERROR for the first err_cyc granted cycles, BUSY up to lat, then ACCESS.
  int   lat     = 1;
  int   err_cyc = 0;
  int   rc      = 0;

  always_comb begin
    ramstate = FREE;
    if (ramREN || ramWEN) begin
      if (rc < lat) ramstate = (rc < err_cyc) ? ERROR : BUSY;
      else          ramstate = ACCESS;
    end
  end
  assign ramload = rd_data(ramaddr);

  always @(posedge CLK) begin
    if (!(ramREN || ramWEN) || ramstate == ACCESS) rc <= 0;
    else                                           rc <= rc + 1;
  end

  typedef struct {
    logic  wr;
    word_t addr;
    word_t data;
  } exp_t;

  exp_t dq[$];
  exp_t iq[$];
  byte  glog[$];

  always @(negedge CLK) begin
    if (nRST) begin
      if (!dwait) begin
        glog.push_back(8'h44);
        if (dq.size() == 0) begin
          chk("d_unexpected_pulse", 32'(dwait), 32'd1);
        end else begin
          exp_t e;
          e = dq.pop_front();
          chk("d_wen", 32'(ramWEN), 32'(e.wr));
          chk("d_addr", ramaddr, e.addr);
          if (e.wr) chk("d_store", ramstore, e.data);
          else      chk("d_load", dload, e.data);
          chk("d_iwait_hi", 32'(iwait), 32'd1);
        end
      end
      if (!iwait) begin
        glog.push_back(8'h49);
        if (iq.size() == 0) begin
          chk("i_unexpected_pulse", 32'(iwait), 32'd1);
        end else begin
          exp_t e;
          e = iq.pop_front();
          chk("i_addr", ramaddr, e.addr);
          chk("i_load", iload, e.data);
          chk("i_starve_clr", 32'(dut.starve_q), 32'd0);
        end
      end
    end
  end

  // mode: 0 read, 1 write, 2 random read/write, 3 dREN+dWEN together
  task automatic dcache_seq(input int n, input int mode, input word_t base, input bit rnd);
    for (int i = 0; i < n; i++) begin
      logic  wr;
      word_t a, d;
      int    cyc;
      wr = (mode == 1 || mode == 3) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      a  = rnd ? word_t'($urandom) : base + word_t'(i);
      d  = word_t'($urandom);
      daddr  = a;
      dstore = d;
      dWEN   = wr;
      dREN   = (mode == 3) ? 1'b1 : ~wr;
      dq.push_back('{wr, a, wr ? d : rd_data(a)});
      cyc = 0;
      do begin
        @(negedge CLK);
        cyc++;
      end while (dwait && cyc < 200);
      if (dwait) begin
        chk("d_timeout", 32'(dwait), 32'd0);
        break;
      end
      @(posedge CLK);
      #1;
    end
    dREN = 1'b0;
    dWEN = 1'b0;
  endtask

  task automatic icache_seq(input int n, input word_t base, input bit rnd);
    for (int i = 0; i < n; i++) begin
      word_t a;
      int    cyc;
      a = rnd ? word_t'($urandom) : base + word_t'(i);
      iaddr = a;
      iREN  = 1'b1;
      iq.push_back('{1'b0, a, rd_data(a)});
      cyc = 0;
      do begin
        @(negedge CLK);
        cyc++;
      end while (iwait && cyc < 200);
      if (iwait) begin
        chk("i_timeout", 32'(iwait), 32'd0);
        break;
      end
      @(posedge CLK);
      #1;
    end
    iREN = 1'b0;
  endtask

  task automatic gap();
    repeat (2) @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    nRST = 1'b0; dREN = 1'b0; dWEN = 1'b0; iREN = 1'b0;
    daddr = 32'h1234_5678; dstore = 32'hCAFE_F00D; iaddr = 32'h0BAD_0BAD;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_dwait", 32'(dwait), 32'd1);
    chk("rst_iwait", 32'(iwait), 32'd1);
    chk("rst_ramREN", 32'(ramREN), 32'd0);
    chk("rst_ramWEN", 32'(ramWEN), 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_ramstore", ramstore, 32'd0);
    chk("rst_dload", dload, 32'd0);
    chk("rst_iload", iload, 32'd0);
    nRST = 1'b1;
    gap();

    // dcache read, ACCESS on the second granted cycle
    lat = 1; err_cyc = 0;
    fork
      dcache_seq(1, 0, 32'h0, 1'b0);
      begin
        @(posedge CLK); #2;
        chk("rd_ramREN_t1", 32'(ramREN), 32'd1);
        chk("rd_ramaddr_t1", ramaddr, 32'h0);
        chk("rd_dwait_busy", 32'(dwait), 32'd1);
        @(posedge CLK); #2;
        chk("rd_dwait_access", 32'(dwait), 32'd0);
        chk("rd_dload", dload, 32'hDEAD_BEEF);
        @(posedge CLK); #2;
        chk("rd_idle_ramREN", 32'(ramREN), 32'd0);
        chk("rd_idle_dload", dload, 32'd0);
      end
    join
    gap();

    // simultaneous dREN, dWEN and iREN
    fork
      dcache_seq(1, 3, 32'h0000_0100, 1'b0);
      icache_seq(1, 32'h0000_0200, 1'b0);
      begin
        @(posedge CLK); #2;
        chk("sim_ramWEN", 32'(ramWEN), 32'd1);
        chk("sim_ramREN", 32'(ramREN), 32'd0);
        chk("sim_ramaddr", ramaddr, 32'h0000_0100);
        chk("sim_iwait", 32'(iwait), 32'd1);
      end
    join
    gap();

    // starvation guard: 5th grant must be icache
    glog.delete();
    fork
      dcache_seq(8, 0, 32'h0000_1000, 1'b0);
      icache_seq(1, 32'h0000_2000, 1'b0);
    join
    chk("starve_len", 32'(glog.size()), 32'd9);
    if (glog.size() >= 5) chk("starve_grant5", 32'(glog[4]), 32'h49);
    nd = 0;
    for (int i = 0; i < glog.size() && glog[i] == 8'h44; i++) nd++;
    chk("starve_d_first", 32'(nd), 32'd4);
    gap();

    // ERROR retried three cycles then ACCESS
    lat = 3; err_cyc = 3;
    fork
      dcache_seq(1, 0, 32'h0000_0300, 1'b0);
      begin
        @(posedge CLK); #2;
        for (int i = 0; i < 3; i++) begin
          chk("err_ramstate", 32'(ramstate), 32'(ERROR));
          chk("err_ramREN", 32'(ramREN), 32'd1);
          chk("err_dwait", 32'(dwait), 32'd1);
          @(posedge CLK); #2;
        end
        chk("err_access_ramREN", 32'(ramREN), 32'd1);
        chk("err_access_dwait", 32'(dwait), 32'd0);
      end
    join
    err_cyc = 0;
    gap();

    // dREN dropped during BUSY, pending icache then served
    lat = 6;
    fork
      icache_seq(1, 32'h0000_0400, 1'b0);
      begin
        daddr = 32'h0000_0500;
        dREN  = 1'b1;
        @(posedge CLK); #1;
        chk("drop_ramREN", 32'(ramREN), 32'd1);
        chk("drop_ramaddr", ramaddr, 32'h0000_0500);
        dREN = 1'b0;
        #1;
        chk("drop_dwait", 32'(dwait), 32'd1);
        @(posedge CLK); #2;
        chk("drop_idle_ramREN", 32'(ramREN), 32'd0);
        chk("drop_idle_state", 32'(dut.state_q), 32'(IDLE));
      end
    join
    gap();

    // reset mid-DWRITE while RAM is BUSY
    lat = 10;
    daddr = 32'h0000_0600; dstore = 32'h1111_2222; dWEN = 1'b1;
    @(posedge CLK); #1;
    chk("rstw_ramWEN", 32'(ramWEN), 32'd1);
    @(posedge CLK); #1;
    nRST = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    dWEN = 1'b0;
    chk("rstw_state", 32'(dut.state_q), 32'(IDLE));
    chk("rstw_ramWEN_drop", 32'(ramWEN), 32'd0);
    chk("rstw_dwait", 32'(dwait), 32'd1);
    chk("rstw_iwait", 32'(iwait), 32'd1);
    gap();

    // mixed random traffic at two latencies
    lat = 2;
    fork
      dcache_seq(6, 2, 32'h0, 1'b1);
      icache_seq(6, 32'h0, 1'b1);
    join
    gap();
    lat = 0;
    fork
      dcache_seq(6, 2, 32'h0, 1'b1);
      icache_seq(6, 32'h0, 1'b1);
    join
    gap();

    chk("dq_drained", 32'(dq.size()), 32'd0);
    chk("iq_drained", 32'(iq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
